// File: rtl/reg_wb_arbiter_pkg.sv
// Shared constants, grant encoding and the winner-selection helper for the
// register-file writeback arbiter. Register file and decode reuse these too.
package reg_wb_arbiter_pkg;

  localparam int               REG_NUM          = 32;
  localparam int               ADDR_W           = 5;
  localparam int               DATA_W           = 32;
  localparam logic [ADDR_W-1:0] REG_ZERO        = 5'd0;
  localparam int               STARVE_LIMIT_DEF = 4;

  // Which requester owns the write port in the current cycle.
  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_A    = 2'd1,
    GNT_B    = 2'd2
  } grant_e;

  // A is preferred (single-cycle path keeps the pipeline moving) unless B has
  // been waiting long enough to be forced through.
  function automatic grant_e pick_winner(input logic a_valid,
                                         input logic b_valid,
                                         input logic b_starved);
    grant_e win;
    if (a_valid && (!b_valid || !b_starved)) begin
      win = GNT_A;
    end else if (b_valid) begin
      win = GNT_B;
    end else begin
      win = GNT_NONE;
    end
    return win;
  endfunction

endpackage

// File: rtl/reg_wb_arbiter_if.sv
// Writeback, reservation and hazard-read bundle shared by the writeback
// sources, the decode stage and the arbiter. master = surrounding pipeline,
// slave = arbiter.
interface reg_wb_arbiter_if #(
  parameter int ADDR_W = reg_wb_arbiter_pkg::ADDR_W,
  parameter int DATA_W = reg_wb_arbiter_pkg::DATA_W
);

  logic              reqA_valid_i;
  logic [ADDR_W-1:0] reqA_addr_i;
  logic [DATA_W-1:0] reqA_data_i;
  logic              reqA_ready_o;

  logic              reqB_valid_i;
  logic [ADDR_W-1:0] reqB_addr_i;
  logic [DATA_W-1:0] reqB_data_i;
  logic              reqB_ready_o;

  logic              rsv_valid_i;
  logic [ADDR_W-1:0] rsv_addr_i;

  logic [ADDR_W-1:0] RSaddr_i;
  logic [ADDR_W-1:0] RTaddr_i;
  logic              stall_o;

  logic              RegWrite_o;
  logic [ADDR_W-1:0] RDaddr_o;
  logic [DATA_W-1:0] RDdata_o;

  modport master (
    output reqA_valid_i, reqA_addr_i, reqA_data_i,
    output reqB_valid_i, reqB_addr_i, reqB_data_i,
    output rsv_valid_i, rsv_addr_i, RSaddr_i, RTaddr_i,
    input  reqA_ready_o, reqB_ready_o, stall_o,
    input  RegWrite_o, RDaddr_o, RDdata_o
  );

  modport slave (
    input  reqA_valid_i, reqA_addr_i, reqA_data_i,
    input  reqB_valid_i, reqB_addr_i, reqB_data_i,
    input  rsv_valid_i, rsv_addr_i, RSaddr_i, RTaddr_i,
    output reqA_ready_o, reqB_ready_o, stall_o,
    output RegWrite_o, RDaddr_o, RDdata_o
  );

endinterface

// File: rtl/reg_scoreboard.sv
// Per-register busy bits for destinations of the multi-cycle B path.
// A reservation sets a bit, a completed B write clears it; when both hit the
// same register on one edge the new reservation wins. Register 0 never
// becomes busy.
module reg_scoreboard
  import reg_wb_arbiter_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              set_valid,
  input  logic [ADDR_W-1:0] set_addr,
  input  logic              clr_valid,
  input  logic [ADDR_W-1:0] clr_addr,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  output logic              rs_busy,
  output logic              rt_busy
);

  logic [REG_NUM-1:0] busy_r;
  logic [REG_NUM-1:0] busy_nxt_s;

  // Next busy vector: set has priority over clear for the same register.
  always_comb begin
    busy_nxt_s = busy_r;
    for (int i = 0; i < REG_NUM; i++) begin
      if (set_valid && (set_addr != REG_ZERO) && (set_addr == ADDR_W'(i))) begin
        busy_nxt_s[i] = 1'b1;
      end else if (clr_valid && (clr_addr == ADDR_W'(i))) begin
        busy_nxt_s[i] = 1'b0;
      end else begin
        busy_nxt_s[i] = busy_r[i];
      end
    end
  end

  // Busy state register, cleared by reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      busy_r <= {REG_NUM{1'b0}};
    end else begin
      busy_r <= busy_nxt_s;
    end
  end

  assign rs_busy = busy_r[rs_addr];
  assign rt_busy = busy_r[rt_addr];

endmodule

// File: rtl/reg_wb_arbiter.sv
// Owns the single register-file write port and shares it between the ALU
// writeback (A) and the load/mul writeback (B). A normally wins; B is forced
// through once it has waited STARVE_LIMIT cycles. The winning write is
// registered one cycle before it reaches the register file, and decode is
// stalled on busy B destinations and on the write sitting in that stage.
module reg_wb_arbiter #(
  parameter int DATA_W       = reg_wb_arbiter_pkg::DATA_W,
  parameter int ADDR_W       = reg_wb_arbiter_pkg::ADDR_W,
  parameter int STARVE_LIMIT = reg_wb_arbiter_pkg::STARVE_LIMIT_DEF
) (
  input  logic            clk_i,
  input  logic            rst_i,
  reg_wb_arbiter_if.slave bus
);

  import reg_wb_arbiter_pkg::*;

  localparam int               CNT_W    = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(STARVE_LIMIT);
  localparam logic [ADDR_W-1:0] ADDR_ZERO = ADDR_W'(REG_ZERO);

  grant_e            grant_s;
  logic              a_xfer_s;
  logic              b_xfer_s;
  logic              b_starved_s;
  logic [CNT_W-1:0]  starve_cnt_r;
  logic [CNT_W-1:0]  starve_cnt_nxt_s;

  logic              win_valid_s;
  logic [ADDR_W-1:0] win_addr_s;
  logic [DATA_W-1:0] win_data_s;

  logic              wr_en_r;
  logic [ADDR_W-1:0] wr_addr_r;
  logic [DATA_W-1:0] wr_data_r;

  logic              rs_busy_s;
  logic              rt_busy_s;
  logic              wb_hit_s;

  // Grant decision; nothing is accepted while reset is held.
  always_comb begin
    b_starved_s = (starve_cnt_r == CNT_MAX);
    if (rst_i) begin
      grant_s = GNT_NONE;
    end else begin
      grant_s = pick_winner(bus.reqA_valid_i, bus.reqB_valid_i, b_starved_s);
    end
    a_xfer_s = (grant_s == GNT_A);
    b_xfer_s = (grant_s == GNT_B);
  end

  assign bus.reqA_ready_o = a_xfer_s;
  assign bus.reqB_ready_o = b_xfer_s;

  // Starve counter next value: counts B waiting cycles, saturates, and drops
  // to zero once B is served or withdraws.
  always_comb begin
    if (bus.reqB_valid_i && !b_xfer_s) begin
      if (b_starved_s) begin
        starve_cnt_nxt_s = starve_cnt_r;
      end else begin
        starve_cnt_nxt_s = starve_cnt_r + CNT_ONE;
      end
    end else begin
      starve_cnt_nxt_s = CNT_ZERO;
    end
  end

  // Starve counter register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      starve_cnt_r <= CNT_ZERO;
    end else begin
      starve_cnt_r <= starve_cnt_nxt_s;
    end
  end

  // Select the winner's address/data for the output stage.
  always_comb begin
    case (grant_s)
      GNT_A: begin
        win_valid_s = 1'b1;
        win_addr_s  = bus.reqA_addr_i;
        win_data_s  = bus.reqA_data_i;
      end
      GNT_B: begin
        win_valid_s = 1'b1;
        win_addr_s  = bus.reqB_addr_i;
        win_data_s  = bus.reqB_data_i;
      end
      default: begin
        win_valid_s = 1'b0;
        win_addr_s  = wr_addr_r;
        win_data_s  = wr_data_r;
      end
    endcase
  end

  // Output stage: one write per cycle, register 0 is never enabled; address
  // and data hold when nothing is granted.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_en_r   <= 1'b0;
      wr_addr_r <= ADDR_ZERO;
      wr_data_r <= {DATA_W{1'b0}};
    end else begin
      wr_en_r   <= win_valid_s && (win_addr_s != ADDR_ZERO);
      wr_addr_r <= win_addr_s;
      wr_data_r <= win_data_s;
    end
  end

  assign bus.RegWrite_o = wr_en_r;
  assign bus.RDaddr_o   = wr_addr_r;
  assign bus.RDdata_o   = wr_data_r;

  reg_scoreboard u_scoreboard (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .set_valid (bus.rsv_valid_i),
    .set_addr  (bus.rsv_addr_i),
    .clr_valid (b_xfer_s),
    .clr_addr  (bus.reqB_addr_i),
    .rs_addr   (bus.RSaddr_i),
    .rt_addr   (bus.RTaddr_i),
    .rs_busy   (rs_busy_s),
    .rt_busy   (rt_busy_s)
  );

  // Decode hazard: busy B destination, or the write not yet in the register file.
  always_comb begin
    wb_hit_s = wr_en_r && (wr_addr_r != ADDR_ZERO) &&
               ((wr_addr_r == bus.RSaddr_i) || (wr_addr_r == bus.RTaddr_i));
    bus.stall_o = rs_busy_s | rt_busy_s | wb_hit_s;
  end

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Self-checking bench for reg_wb_arbiter: directed scenarios with literal
// expectations, then randomized traffic compared every cycle against a
// behavioural model of the arbitration, scoreboard and output stage.
module tb_reg_wb_arbiter;
  timeunit 1ns;
  timeprecision 100ps;

  localparam int LIMIT = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  reg_wb_arbiter_if #(.ADDR_W(5), .DATA_W(32)) bus ();

  reg_wb_arbiter #(.DATA_W(32), .ADDR_W(5), .STARVE_LIMIT(LIMIT)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int checks = 0;
  int failures = 0;
  bit checking = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Register file fed by the DUT write port.
  logic [31:0] rf [32];
  always @(posedge clk) begin
    if (bus.RegWrite_o === 1'b1) rf[bus.RDaddr_o] <= bus.RDdata_o;
  end

  // ---------------- behavioural model ----------------
  int          m_wait;     // consecutive cycles B has been left waiting
  logic [31:0] m_busy;     // one bit per register
  logic        m_we;
  logic [4:0]  m_addr;
  logic [31:0] m_data;
  logic        acc_a, acc_b;
  logic        e_ra, e_rb, e_stall;
  logic [31:0] m_busy_nx;

  always_comb begin
    e_ra = !rst && bus.reqA_valid_i && (!bus.reqB_valid_i || (m_wait < LIMIT));
    e_rb = !rst && bus.reqB_valid_i && !e_ra;
    m_busy_nx = m_busy;
    if (e_rb) m_busy_nx[bus.reqB_addr_i] = 1'b0;
    if (bus.rsv_valid_i && (bus.rsv_addr_i != 5'd0)) m_busy_nx[bus.rsv_addr_i] = 1'b1;
    e_stall = m_busy[bus.RSaddr_i] | m_busy[bus.RTaddr_i] |
              (m_we && (m_addr != 5'd0) && ((m_addr == bus.RSaddr_i) || (m_addr == bus.RTaddr_i)));
  end

  always @(posedge clk) begin
    if (rst) begin
      m_wait <= 0;
      m_busy <= 32'd0;
      m_we   <= 1'b0;
      m_addr <= 5'd0;
      m_data <= 32'd0;
    end else begin
      if (e_ra) begin
        m_we <= (bus.reqA_addr_i != 5'd0); m_addr <= bus.reqA_addr_i; m_data <= bus.reqA_data_i;
      end else if (e_rb) begin
        m_we <= (bus.reqB_addr_i != 5'd0); m_addr <= bus.reqB_addr_i; m_data <= bus.reqB_data_i;
      end else begin
        m_we <= 1'b0;
      end
      m_wait <= (bus.reqB_valid_i && !e_rb) ? ((m_wait < LIMIT) ? m_wait + 1 : LIMIT) : 0;
      m_busy <= m_busy_nx;
    end
    acc_a <= e_ra;
    acc_b <= e_rb;
  end

  // Compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    if (checking) begin
      chk("readyA", bus.reqA_ready_o, e_ra);
      chk("readyB", bus.reqB_ready_o, e_rb);
      chk("stall", bus.stall_o, e_stall);
      chk("RegWrite", bus.RegWrite_o, m_we);
      chk("RDaddr", bus.RDaddr_o, m_addr);
      chk("RDdata", bus.RDdata_o, m_data);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.reqA_valid_i = 1'b0; bus.reqA_addr_i = 5'd0; bus.reqA_data_i = 32'd0;
    bus.reqB_valid_i = 1'b0; bus.reqB_addr_i = 5'd0; bus.reqB_data_i = 32'd0;
    bus.rsv_valid_i  = 1'b0; bus.rsv_addr_i  = 5'd0;
    bus.RSaddr_i     = 5'd0; bus.RTaddr_i    = 5'd0;
  endtask

  initial begin
    idle();
    rst = 1'b1;
    bus.reqA_valid_i = 1'b1; bus.reqA_addr_i = 5'd1; bus.reqA_data_i = 32'h11;
    bus.reqB_valid_i = 1'b1; bus.reqB_addr_i = 5'd2; bus.reqB_data_i = 32'h22;
    tick();
    checking = 1'b1;
    // 1. Reset: no readys, no write, no stall on any address
    chk("rst_readyA", bus.reqA_ready_o, 32'd0);
    chk("rst_readyB", bus.reqB_ready_o, 32'd0);
    chk("rst_RegWrite", bus.RegWrite_o, 32'd0);
    for (int i = 0; i < 32; i++) begin
      bus.RSaddr_i = 5'(i);
      bus.RTaddr_i = 5'(31 - i);
      #0.1;
      chk("rst_stall", bus.stall_o, 32'd0);
    end
    tick();

    // 2. A alone
    rst = 1'b0;
    idle();
    bus.reqA_valid_i = 1'b1; bus.reqA_addr_i = 5'd5; bus.reqA_data_i = 32'h1234;
    @(negedge clk);
    chk("t2_readyA", bus.reqA_ready_o, 32'd1);
    tick();
    bus.reqA_valid_i = 1'b0;
    @(negedge clk);
    chk("t2_RegWrite", bus.RegWrite_o, 32'd1);
    chk("t2_RDaddr", bus.RDaddr_o, 32'd5);
    chk("t2_RDdata", bus.RDdata_o, 32'h1234);
    tick();
    @(negedge clk);
    chk("t2_rf5", rf[5], 32'h1234);

    // 3. Starvation: A four times, then B forced through
    tick();
    bus.reqA_valid_i = 1'b1; bus.reqA_addr_i = 5'd2; bus.reqA_data_i = 32'hA;
    bus.reqB_valid_i = 1'b1; bus.reqB_addr_i = 5'd7; bus.reqB_data_i = 32'hBEEF;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("t3_readyA_early", bus.reqA_ready_o, 32'd1);
      chk("t3_readyB_early", bus.reqB_ready_o, 32'd0);
      tick();
    end
    @(negedge clk);
    chk("t3_readyB_5th", bus.reqB_ready_o, 32'd1);
    chk("t3_readyA_5th", bus.reqA_ready_o, 32'd0);
    tick();
    bus.reqB_valid_i = 1'b0;
    @(negedge clk);
    chk("t3_RegWrite", bus.RegWrite_o, 32'd1);
    chk("t3_RDaddr", bus.RDaddr_o, 32'd7);
    chk("t3_RDdata", bus.RDdata_o, 32'hBEEF);
    tick();
    bus.reqB_valid_i = 1'b1; bus.reqB_addr_i = 5'd8; bus.reqB_data_i = 32'h8888;
    @(negedge clk);
    chk("t3_counter_cleared", bus.reqA_ready_o, 32'd1);
    tick();
    bus.reqA_valid_i = 1'b0;
    @(negedge clk);
    chk("t3_B_alone", bus.reqB_ready_o, 32'd1);

    // 4. Scoreboard reservation and release
    tick();
    idle();
    bus.rsv_valid_i = 1'b1; bus.rsv_addr_i = 5'd9;
    tick();
    bus.rsv_valid_i = 1'b0; bus.RSaddr_i = 5'd9;
    @(negedge clk);
    chk("t4_stall_busy", bus.stall_o, 32'd1);
    tick();
    bus.reqB_valid_i = 1'b1; bus.reqB_addr_i = 5'd9; bus.reqB_data_i = 32'h99;
    @(negedge clk);
    chk("t4_readyB", bus.reqB_ready_o, 32'd1);
    chk("t4_stall_before_clear", bus.stall_o, 32'd1);
    tick();
    bus.reqB_valid_i = 1'b0;
    @(negedge clk);
    chk("t4_stall_wb_stage", bus.stall_o, 32'd1);
    chk("t4_RDaddr", bus.RDaddr_o, 32'd9);
    tick();
    @(negedge clk);
    chk("t4_stall_released", bus.stall_o, 32'd0);

    // 5. Same-edge set and clear of register 3
    tick();
    bus.rsv_valid_i = 1'b1; bus.rsv_addr_i = 5'd3;
    bus.reqB_valid_i = 1'b1; bus.reqB_addr_i = 5'd3; bus.reqB_data_i = 32'h33;
    bus.RSaddr_i = 5'd0;
    @(negedge clk);
    chk("t5_readyB", bus.reqB_ready_o, 32'd1);
    tick();
    idle();
    bus.RSaddr_i = 5'd3;
    @(negedge clk);
    chk("t5_stall", bus.stall_o, 32'd1);
    tick();
    @(negedge clk);
    chk("t5_RegWrite_idle", bus.RegWrite_o, 32'd0);
    chk("t5_busy_kept", bus.stall_o, 32'd1);

    // 6. Register 0
    tick();
    idle();
    bus.reqA_valid_i = 1'b1; bus.reqA_addr_i = 5'd0; bus.reqA_data_i = 32'hFFFF;
    @(negedge clk);
    chk("t6_readyA", bus.reqA_ready_o, 32'd1);
    tick();
    bus.reqA_valid_i = 1'b0;
    bus.rsv_valid_i = 1'b1; bus.rsv_addr_i = 5'd0;
    @(negedge clk);
    chk("t6_RegWrite", bus.RegWrite_o, 32'd0);
    tick();
    bus.rsv_valid_i = 1'b0;
    @(negedge clk);
    chk("t6_stall_r0", bus.stall_o, 32'd0);

    // Randomized traffic honouring the hold-until-ready rule
    tick();
    idle();
    for (int n = 0; n < 3000; n++) begin
      if (!bus.reqA_valid_i || acc_a) begin
        bus.reqA_valid_i = ($urandom_range(0, 99) < 55);
        bus.reqA_addr_i  = 5'($urandom_range(0, 15));
        bus.reqA_data_i  = $urandom;
      end
      if (!bus.reqB_valid_i || acc_b) begin
        bus.reqB_valid_i = ($urandom_range(0, 99) < 40);
        bus.reqB_addr_i  = 5'($urandom_range(0, 15));
        bus.reqB_data_i  = $urandom;
      end
      bus.rsv_valid_i = ($urandom_range(0, 99) < 20);
      bus.rsv_addr_i  = 5'($urandom_range(0, 15));
      bus.RSaddr_i    = 5'($urandom_range(0, 15));
      bus.RTaddr_i    = 5'($urandom_range(0, 15));
      rst = ($urandom_range(0, 199) == 0);
      tick();
    end

    checking = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
